i2c_slave_rx: RTL and testbench

//  Write-only I2C slave receiver that sits on the scl/sda bus driven by the APB I2C master (top_level).

---
 rtl/i2c_slave_rx_if.sv | 24 ++
 rtl/i2c_slave_rx.sv | 232 +++++++++++++++++++++++
 tb/tb_i2c_slave_rx.sv | 381 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_slave_rx_if.sv
// Bus and receive-side signals of the I2C slave receiver.
// The slave modport faces the design; the master modport faces the pad/bench side.
interface i2c_slave_rx_if;
    logic       scl_in;
    logic       sda_in;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       busy;
    logic       addr_match;
    logic       overflow;
    logic [4:0] rx_count;

    modport slave (
        input  scl_in, sda_in, rx_ready,
        output sda_oe, rx_data, rx_valid, busy, addr_match, overflow, rx_count
    );

    modport master (
        output scl_in, sda_in, rx_ready,
        input  sda_oe, rx_data, rx_valid, busy, addr_match, overflow, rx_count
    );
endinterface

// File: rtl/i2c_slave_rx.sv
// Write-only I2C slave receiver: oversampled START/STOP detection, 7-bit address match,
// ACK generation and a receive FIFO drained through a valid/ready handshake.
module i2c_slave_rx #(
    parameter logic [6:0]  SLAVE_ADDR = 7'h10,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input logic           core_clk,
    input logic           core_rst,
    i2c_slave_rx_if.slave bus
);
    localparam int unsigned PtrW    = $clog2(FIFO_DEPTH);
    localparam logic [PtrW:0] FullCnt = (PtrW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StData,
        StDataAck,
        StIgnore
    } state_e;

    // Synchronizers and edge registers
    logic scl_meta_q, scl_sync_q, scl_prev_q;
    logic sda_meta_q, sda_sync_q, sda_prev_q;
    logic scl_rise, scl_fall, start_det, stop_det;

    // FSM state
    state_e     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] shift_q, shift_d;
    logic       ack_en_q, ack_en_d;
    logic       ack_phase_q, ack_phase_d;
    logic       sda_oe_q, sda_oe_d;
    logic       busy_q, busy_d;
    logic       addr_match_q, addr_match_d;
    logic       overflow_q, overflow_d;
    logic [4:0] rx_count_q, rx_count_d;
    logic [7:0] byte_in;
    logic       addr_hit;
    logic       push;

    // FIFO
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]   count_q;
    logic            fifo_full, fifo_valid, pop;

    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            scl_meta_q <= 1'b1;
            scl_sync_q <= 1'b1;
            scl_prev_q <= 1'b1;
            sda_meta_q <= 1'b1;
            sda_sync_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_meta_q <= bus.scl_in;
            scl_sync_q <= scl_meta_q;
            scl_prev_q <= scl_sync_q;
            sda_meta_q <= bus.sda_in;
            sda_sync_q <= sda_meta_q;
            sda_prev_q <= sda_sync_q;
        end
    end

    assign scl_rise  = scl_sync_q & ~scl_prev_q;
    assign scl_fall  = ~scl_sync_q & scl_prev_q;
    assign start_det = scl_sync_q & scl_prev_q & sda_prev_q & ~sda_sync_q;
    assign stop_det  = scl_sync_q & scl_prev_q & ~sda_prev_q & sda_sync_q;

    assign byte_in  = {shift_q, sda_sync_q};
    assign addr_hit = (byte_in[7:1] == SLAVE_ADDR) && !byte_in[0];

    assign fifo_valid = (count_q != '0);
    assign fifo_full  = (count_q == FullCnt);
    assign pop        = fifo_valid & bus.rx_ready;

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        ack_en_d     = ack_en_q;
        ack_phase_d  = ack_phase_q;
        sda_oe_d     = sda_oe_q;
        busy_d       = busy_q;
        addr_match_d = addr_match_q;
        overflow_d   = overflow_q;
        rx_count_d   = rx_count_q;
        push         = 1'b0;

        // Bus conditions win over bit sampling in the same cycle
        if (stop_det) begin
            state_d      = StIdle;
            busy_d       = 1'b0;
            addr_match_d = 1'b0;
            sda_oe_d     = 1'b0;
            bit_cnt_d    = '0;
            ack_phase_d  = 1'b0;
        end else if (start_det) begin
            state_d      = StAddr;
            busy_d       = 1'b1;
            addr_match_d = 1'b0;
            sda_oe_d     = 1'b0;
            bit_cnt_d    = '0;
            rx_count_d   = '0;
            ack_phase_d  = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                end
                StAddr: begin
                    if (scl_rise) begin
                        shift_d   = byte_in[6:0];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            ack_phase_d = 1'b0;
                            if (addr_hit) begin
                                state_d      = StAddrAck;
                                addr_match_d = 1'b1;
                                ack_en_d     = 1'b1;
                            end else begin
                                state_d = StIgnore;
                            end
                        end
                    end
                end
                StAddrAck, StDataAck: begin
                    // First fall opens the ACK slot, second fall closes it
                    if (scl_fall) begin
                        if (!ack_phase_q) begin
                            ack_phase_d = 1'b1;
                            sda_oe_d    = ack_en_q;
                        end else begin
                            ack_phase_d = 1'b0;
                            sda_oe_d    = 1'b0;
                            state_d     = StData;
                            bit_cnt_d   = '0;
                        end
                    end
                end
                StData: begin
                    if (scl_rise) begin
                        shift_d   = byte_in[6:0];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d     = StDataAck;
                            ack_phase_d = 1'b0;
                            if (fifo_full && !pop) begin
                                overflow_d = 1'b1;
                                ack_en_d   = 1'b0;
                            end else begin
                                push     = 1'b1;
                                ack_en_d = 1'b1;
                                if (rx_count_q != 5'd31) begin
                                    rx_count_d = rx_count_q + 5'd1;
                                end
                            end
                        end
                    end
                end
                StIgnore: begin
                    sda_oe_d = 1'b0;
                end
                default: begin
                    state_d  = StIdle;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            state_q      <= StIdle;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            ack_en_q     <= 1'b0;
            ack_phase_q  <= 1'b0;
            sda_oe_q     <= 1'b0;
            busy_q       <= 1'b0;
            addr_match_q <= 1'b0;
            overflow_q   <= 1'b0;
            rx_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            ack_en_q     <= ack_en_d;
            ack_phase_q  <= ack_phase_d;
            sda_oe_q     <= sda_oe_d;
            busy_q       <= busy_d;
            addr_match_q <= addr_match_d;
            overflow_q   <= overflow_d;
            rx_count_q   <= rx_count_d;
        end
    end

    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + (PtrW + 1)'(1);
                2'b01:   count_q <= count_q - (PtrW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge core_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= byte_in;
        end
    end

    assign bus.sda_oe     = sda_oe_q;
    assign bus.rx_valid   = fifo_valid;
    assign bus.rx_data    = fifo_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign bus.busy       = busy_q;
    assign bus.addr_match = addr_match_q;
    assign bus.overflow   = overflow_q;
    assign bus.rx_count   = rx_count_q;
endmodule

// File: tb/tb_i2c_slave_rx.sv
// Self-checking bench for i2c_slave_rx: bit-banged I2C master plus a byte scoreboard.
module tb_i2c_slave_rx;
    localparam int Q = 8;  // core_clk cycles per quarter SCL period

    logic       core_clk = 1'b0;
    logic       core_rst = 1'b1;
    logic       sda_m    = 1'b1;
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q [$];

    i2c_slave_rx_if bus ();
    assign bus.sda_in = sda_m & ~bus.sda_oe;

    i2c_slave_rx #(
        .SLAVE_ADDR(7'h10),
        .FIFO_DEPTH(8)
    ) dut (
        .core_clk(core_clk),
        .core_rst(core_rst),
        .bus     (bus)
    );

    always #5 core_clk = ~core_clk;

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge core_clk);
    endtask

    task automatic do_reset();
        bus.scl_in = 1'b1;
        sda_m      = 1'b1;
        core_rst   = 1'b1;
        wait_cyc(2);
        core_rst   = 1'b0;
        wait_cyc(2);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1;
        wait_cyc(Q);
        bus.scl_in = 1'b1;
        wait_cyc(Q);
        sda_m = 1'b0;
        wait_cyc(Q);
        bus.scl_in = 1'b0;
        wait_cyc(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0;
        wait_cyc(Q);
        bus.scl_in = 1'b1;
        wait_cyc(Q);
        sda_m = 1'b1;
        wait_cyc(2 * Q);
    endtask

    // Sends the top nbits of b MSB first. With pulse set, rx_ready is raised for exactly
    // the cycle in which the last bit's push lands, and the head byte seen then is returned.
    task automatic send_bits(input logic [7:0] b, input int nbits, input bit pulse,
                             output logic [7:0] popped);
        popped = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            sda_m = b[i];
            wait_cyc(Q);
            bus.scl_in = 1'b1;
            if (pulse && i == 0) begin
                wait_cyc(2);
                popped       = bus.rx_data;
                bus.rx_ready = 1'b1;
                wait_cyc(1);
                bus.rx_ready = 1'b0;
                wait_cyc(2 * Q - 3);
            end else begin
                wait_cyc(2 * Q);
            end
            bus.scl_in = 1'b0;
            wait_cyc(Q);
        end
    endtask

    task automatic ack_slot(output logic acked);
        sda_m = 1'b1;
        wait_cyc(Q);
        bus.scl_in = 1'b1;
        wait_cyc(Q);
        acked = (bus.sda_in === 1'b0);
        wait_cyc(Q);
        bus.scl_in = 1'b0;
        wait_cyc(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic acked);
        logic [7:0] unused;
        send_bits(b, 8, 1'b0, unused);
        ack_slot(acked);
    endtask

    task automatic test_reset();
        bus.rx_ready = 1'b0;
        do_reset();
        n_checks++;
        if (bus.sda_oe !== 1'b0) begin
            n_fail++; $display("FAIL reset_sda_oe: got %b want 0", bus.sda_oe);
        end
        n_checks++;
        if (bus.rx_valid !== 1'b0 || bus.rx_data !== 8'h00) begin
            n_fail++; $display("FAIL reset_fifo: valid %b data %h want 0 00", bus.rx_valid, bus.rx_data);
        end
        n_checks++;
        if ({bus.busy, bus.addr_match, bus.overflow, bus.rx_count} !== 8'h00) begin
            n_fail++; $display("FAIL reset_status: busy %b match %b ovf %b cnt %0d want all 0",
                               bus.busy, bus.addr_match, bus.overflow, bus.rx_count);
        end
    endtask

    task automatic test_basic();
        logic       acked;
        logic [7:0] exp;
        int         n_ack = 0;
        bit         done  = 1'b0;
        int         cyc   = 0;
        bus.rx_ready = 1'b1;
        fork
            begin
                i2c_start();
                n_checks++;
                if (bus.busy !== 1'b1) begin
                    n_fail++; $display("FAIL basic_busy: got %b want 1", bus.busy);
                end
                send_byte(8'h20, acked);
                if (acked) n_ack++;
                n_checks++;
                if (bus.addr_match !== 1'b1) begin
                    n_fail++; $display("FAIL basic_addr_match: got %b want 1", bus.addr_match);
                end
                for (int i = 1; i <= 8; i++) begin
                    exp_q.push_back(8'(i));
                    send_byte(8'(i), acked);
                    if (acked) n_ack++;
                end
                i2c_stop();
                done = 1'b1;
            end
            begin
                while ((!done || exp_q.size() != 0) && cyc < 20000) begin
                    if (bus.rx_valid) begin
                        n_checks++;
                        if (exp_q.size() == 0) begin
                            n_fail++; $display("FAIL basic_extra_byte: got %h want none", bus.rx_data);
                        end else begin
                            exp = exp_q.pop_front();
                            if (bus.rx_data !== exp) begin
                                n_fail++; $display("FAIL basic_data: got %h want %h", bus.rx_data, exp);
                            end
                        end
                    end
                    @(negedge core_clk);
                    cyc++;
                end
            end
        join
        n_checks++;
        if (cyc >= 20000) begin
            n_fail++; $display("FAIL basic_timeout: %0d bytes left want 0", exp_q.size());
        end
        n_checks++;
        if (n_ack != 9) begin
            n_fail++; $display("FAIL basic_acks: got %0d want 9", n_ack);
        end
        n_checks++;
        if (bus.rx_count !== 5'd8 || bus.overflow !== 1'b0) begin
            n_fail++; $display("FAIL basic_count: cnt %0d ovf %b want 8 0", bus.rx_count, bus.overflow);
        end
        n_checks++;
        if (bus.busy !== 1'b0 || bus.addr_match !== 1'b0 || bus.rx_valid !== 1'b0) begin
            n_fail++; $display("FAIL basic_after_stop: busy %b match %b valid %b want 0 0 0",
                               bus.busy, bus.addr_match, bus.rx_valid);
        end
        bus.rx_ready = 1'b0;
    endtask

    task automatic test_no_match();
        logic [7:0] addrs [2] = '{8'h22, 8'h21};
        logic       acked;
        bus.rx_ready = 1'b0;
        foreach (addrs[k]) begin
            i2c_start();
            send_byte(addrs[k], acked);
            n_checks++;
            if (acked !== 1'b0 || bus.addr_match !== 1'b0 || bus.busy !== 1'b1) begin
                n_fail++; $display("FAIL nomatch_addr_%h: ack %b match %b busy %b want 0 0 1",
                                   addrs[k], acked, bus.addr_match, bus.busy);
            end
            send_byte(8'h5A, acked);
            n_checks++;
            if (acked !== 1'b0 || bus.rx_valid !== 1'b0 || bus.rx_count !== 5'd0) begin
                n_fail++; $display("FAIL nomatch_ignore_%h: ack %b valid %b cnt %0d want 0 0 0",
                                   addrs[k], acked, bus.rx_valid, bus.rx_count);
            end
            i2c_stop();
            n_checks++;
            if (bus.busy !== 1'b0) begin
                n_fail++; $display("FAIL nomatch_busy_%h: got %b want 0", addrs[k], bus.busy);
            end
        end
    endtask

    task automatic test_overflow();
        logic       acked;
        logic [7:0] exp;
        int         cyc = 0;
        do_reset();
        bus.rx_ready = 1'b0;
        i2c_start();
        send_byte(8'h20, acked);
        for (int i = 1; i <= 9; i++) begin
            if (i <= 8) exp_q.push_back(8'(i));
            send_byte(8'(i), acked);
            n_checks++;
            if (acked !== (i <= 8)) begin
                n_fail++; $display("FAIL ovf_ack_byte%0d: got %b want %b", i, acked, i <= 8);
            end
        end
        n_checks++;
        if (bus.overflow !== 1'b1 || bus.rx_count !== 5'd8 || bus.rx_valid !== 1'b1) begin
            n_fail++; $display("FAIL ovf_status: ovf %b cnt %0d valid %b want 1 8 1",
                               bus.overflow, bus.rx_count, bus.rx_valid);
        end
        i2c_stop();
        bus.rx_ready = 1'b1;
        while (exp_q.size() != 0 && cyc < 100) begin
            if (bus.rx_valid) begin
                exp = exp_q.pop_front();
                n_checks++;
                if (bus.rx_data !== exp) begin
                    n_fail++; $display("FAIL ovf_data: got %h want %h", bus.rx_data, exp);
                end
            end
            @(negedge core_clk);
            cyc++;
        end
        bus.rx_ready = 1'b0;
        n_checks++;
        if (bus.rx_valid !== 1'b0 || bus.overflow !== 1'b1 || cyc >= 100) begin
            n_fail++; $display("FAIL ovf_drained: valid %b ovf %b cyc %0d want 0 1 <100",
                               bus.rx_valid, bus.overflow, cyc);
        end
    endtask

    task automatic test_full_push_pop();
        logic       acked;
        logic [7:0] popped, exp;
        int         cyc = 0;
        do_reset();
        bus.rx_ready = 1'b0;
        i2c_start();
        send_byte(8'h20, acked);
        for (int i = 1; i <= 8; i++) begin
            exp_q.push_back(8'(i));
            send_byte(8'(i), acked);
        end
        exp_q.push_back(8'h09);
        send_bits(8'h09, 8, 1'b1, popped);
        ack_slot(acked);
        exp = exp_q.pop_front();
        n_checks++;
        if (popped !== exp) begin
            n_fail++; $display("FAIL fullpp_popped: got %h want %h", popped, exp);
        end
        n_checks++;
        if (acked !== 1'b1 || bus.overflow !== 1'b0 || bus.rx_count !== 5'd9) begin
            n_fail++; $display("FAIL fullpp_status: ack %b ovf %b cnt %0d want 1 0 9",
                               acked, bus.overflow, bus.rx_count);
        end
        i2c_stop();
        bus.rx_ready = 1'b1;
        while (exp_q.size() != 0 && cyc < 100) begin
            if (bus.rx_valid) begin
                exp = exp_q.pop_front();
                n_checks++;
                if (bus.rx_data !== exp) begin
                    n_fail++; $display("FAIL fullpp_data: got %h want %h", bus.rx_data, exp);
                end
            end
            @(negedge core_clk);
            cyc++;
        end
        bus.rx_ready = 1'b0;
        n_checks++;
        if (bus.rx_valid !== 1'b0 || cyc >= 100) begin
            n_fail++; $display("FAIL fullpp_drained: valid %b cyc %0d want 0 <100", bus.rx_valid, cyc);
        end
    endtask

    task automatic test_partial();
        logic       acked;
        logic [7:0] unused;
        bus.rx_ready = 1'b0;
        i2c_start();
        send_byte(8'h20, acked);
        send_bits(8'hF0, 4, 1'b0, unused);
        i2c_stop();
        n_checks++;
        if (bus.rx_valid !== 1'b0 || bus.busy !== 1'b0 || bus.rx_count !== 5'd0) begin
            n_fail++; $display("FAIL partial_dropped: valid %b busy %b cnt %0d want 0 0 0",
                               bus.rx_valid, bus.busy, bus.rx_count);
        end
        i2c_start();
        send_byte(8'h20, acked);
        exp_q.push_back(8'hA5);
        send_byte(8'hA5, acked);
        i2c_stop();
        n_checks++;
        if (bus.rx_valid !== 1'b1 || bus.rx_data !== exp_q[0] || bus.rx_count !== 5'd1) begin
            n_fail++; $display("FAIL partial_next: valid %b data %h cnt %0d want 1 %h 1",
                               bus.rx_valid, bus.rx_data, bus.rx_count, exp_q[0]);
        end
        bus.rx_ready = 1'b1;
        wait_cyc(1);
        bus.rx_ready = 1'b0;
        void'(exp_q.pop_front());
    endtask

    task automatic test_reset_mid();
        logic       acked;
        logic [7:0] unused;
        bus.rx_ready = 1'b0;
        i2c_start();
        send_byte(8'h20, acked);
        send_bits(8'h3C, 8, 1'b0, unused);
        sda_m = 1'b1;
        wait_cyc(Q);
        n_checks++;
        if (bus.sda_oe !== 1'b1 || bus.rx_valid !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_in_ack: oe %b valid %b want 1 1", bus.sda_oe, bus.rx_valid);
        end
        core_rst = 1'b1;
        wait_cyc(1);
        n_checks++;
        if (bus.sda_oe !== 1'b0 || bus.rx_valid !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_drop: oe %b valid %b want 0 0", bus.sda_oe, bus.rx_valid);
        end
        core_rst = 1'b0;
        bus.scl_in = 1'b1;
        wait_cyc(2 * Q);
        bus.scl_in = 1'b0;
        wait_cyc(Q);
        send_byte(8'h77, acked);
        n_checks++;
        if (acked !== 1'b0 || bus.rx_valid !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_ignored: ack %b valid %b busy %b want 0 0 0",
                               acked, bus.rx_valid, bus.busy);
        end
        i2c_stop();
        i2c_start();
        send_byte(8'h20, acked);
        send_byte(8'h99, acked);
        i2c_stop();
        n_checks++;
        if (acked !== 1'b1 || bus.rx_data !== 8'h99 || bus.rx_count !== 5'd1) begin
            n_fail++; $display("FAIL rstmid_rejoin: ack %b data %h cnt %0d want 1 99 1",
                               acked, bus.rx_data, bus.rx_count);
        end
    endtask

    initial begin
        bus.scl_in   = 1'b1;
        bus.rx_ready = 1'b0;
        test_reset();
        test_basic();
        test_no_match();
        test_overflow();
        test_full_push_pop();
        test_partial();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
